// File: rtl/driving_status_display.sv
`default_nettype none
// ============================================================================
// Module   : driving_status_display
// Purpose  : Turn lamps, reverse lamp, BCD odometer and 4-digit 7-segment
//            scan driven from the driving-mode controller state.
// Revision : 1.0 - initial release
// ============================================================================
module driving_status_display #(
    parameter int BLINK_DIV = 25_000_000,
    parameter int MILE_DIV  = 100_000_000,
    parameter int SCAN_DIV  = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        power_now,
    input  logic        turn_left_signal,
    input  logic        turn_right_signal,
    input  logic        reverse,
    output logic        left_led,
    output logic        right_led,
    output logic        reverse_led,
    output logic [15:0] mileage,
    output logic [3:0]  seg_en,
    output logic [6:0]  seg_out
);

    localparam logic [3:0] ST_NOT_STARTING = 4'd1;
    localparam logic [3:0] ST_STARTING     = 4'd2;
    localparam logic [3:0] ST_MOVING       = 4'd3;

    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int MW = (MILE_DIV  > 1) ? $clog2(MILE_DIV)  : 1;
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [MW-1:0] MILE_LAST  = MW'(MILE_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic          powered;
    logic          turn_req;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [MW-1:0] mile_cnt;
    logic [15:0]   mileage_inc;
    logic          carry;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    scan_idx;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;

    assign powered  = power_now && (state < 4'd4);
    assign turn_req = turn_left_signal | turn_right_signal;

    // Generator parks at phase 1 while idle so every new request starts lit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!powered || !turn_req) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_led    <= 1'b0;
            right_led   <= 1'b0;
            reverse_led <= 1'b0;
        end else if (!powered) begin
            left_led    <= 1'b0;
            right_led   <= 1'b0;
            reverse_led <= 1'b0;
        end else begin
            reverse_led <= reverse;
            case (state)
                ST_NOT_STARTING: begin
                    left_led  <= turn_left_signal;
                    right_led <= turn_right_signal;
                end
                ST_STARTING, ST_MOVING: begin
                    left_led  <= turn_left_signal  & blink_phase;
                    right_led <= turn_right_signal & blink_phase;
                end
                default: begin
                    left_led  <= 1'b0;
                    right_led <= 1'b0;
                end
            endcase
        end
    end

    // BCD ripple increment; a digit at 9 (or corrupted above) rolls to 0.
    always_comb begin
        mileage_inc = mileage;
        carry       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (mileage[4*i +: 4] >= 4'd9) begin
                    mileage_inc[4*i +: 4] = 4'd0;
                end else begin
                    mileage_inc[4*i +: 4] = mileage[4*i +: 4] + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mile_cnt <= '0;
            mileage  <= '0;
        end else if (!power_now) begin
            mile_cnt <= '0;
            mileage  <= '0;
        end else if (state == ST_MOVING) begin
            if (mile_cnt == MILE_LAST) begin
                mile_cnt <= '0;
                mileage  <= mileage_inc;
            end else begin
                mile_cnt <= mile_cnt + 1'b1;
            end
        end
    end

    assign cur_digit = mileage[4*scan_idx +: 4];

    always_comb begin
        case (cur_digit)
            4'd0:    cur_seg = 7'h3F;
            4'd1:    cur_seg = 7'h06;
            4'd2:    cur_seg = 7'h5B;
            4'd3:    cur_seg = 7'h4F;
            4'd4:    cur_seg = 7'h66;
            4'd5:    cur_seg = 7'h6D;
            4'd6:    cur_seg = 7'h7D;
            4'd7:    cur_seg = 7'h07;
            4'd8:    cur_seg = 7'h7F;
            4'd9:    cur_seg = 7'h6F;
            default: cur_seg = 7'h00;
        endcase
    end

    // Enable and pattern come from the same index in the same edge, so they never disagree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            seg_en   <= 4'd0;
            seg_out  <= 7'd0;
        end else if (!powered) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            seg_en   <= 4'd0;
            seg_out  <= 7'd0;
        end else begin
            seg_en  <= 4'b0001 << scan_idx;
            seg_out <= cur_seg;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_driving_status_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_driving_status_display
// Purpose  : Scoreboard bench for driving_status_display (small dividers).
// Revision : 1.0 - initial release
// ============================================================================
module tb_driving_status_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic        power_now, tl, tr, rev;
    logic        left_led, right_led, reverse_led;
    logic [15:0] mileage;
    logic [3:0]  seg_en;
    logic [6:0]  seg_out;

    logic [3:0]  wstate;
    logic        wpower;
    logic        w_left, w_right, w_rev;
    logic [15:0] w_mileage;
    logic [3:0]  w_seg_en;
    logic [6:0]  w_seg_out;

    always #5 clk = ~clk;

    driving_status_display #(.BLINK_DIV(4), .MILE_DIV(10), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .state(state), .power_now(power_now),
        .turn_left_signal(tl), .turn_right_signal(tr), .reverse(rev),
        .left_led(left_led), .right_led(right_led), .reverse_led(reverse_led),
        .mileage(mileage), .seg_en(seg_en), .seg_out(seg_out)
    );

    // Fast odometer instance so the 9999 rollover is reachable quickly.
    driving_status_display #(.BLINK_DIV(4), .MILE_DIV(1), .SCAN_DIV(2)) dut_wrap (
        .clk(clk), .rst(rst), .state(wstate), .power_now(wpower),
        .turn_left_signal(1'b0), .turn_right_signal(1'b0), .reverse(1'b0),
        .left_led(w_left), .right_led(w_right), .reverse_led(w_rev),
        .mileage(w_mileage), .seg_en(w_seg_en), .seg_out(w_seg_out)
    );

    logic [29:0] main_vec, wrap_vec;
    assign main_vec = {left_led, right_led, reverse_led, mileage, seg_en, seg_out};
    assign wrap_vec = {w_left, w_right, w_rev, w_mileage, w_seg_en, w_seg_out};

    localparam logic [29:0] M_ALL  = 30'h3FFF_FFFF;
    localparam logic [29:0] M_LAMP = 30'h3800_0000;
    localparam logic [29:0] M_MIL  = 30'h07FF_F800;

    typedef struct {
        int          cyc;
        bit          sel;
        logic [29:0] ev;
        logic [29:0] mask;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [29:0] vec(input bit l, input bit r, input bit rv,
                                        input logic [15:0] mil, input logic [3:0] en,
                                        input logic [6:0] seg);
        return {l, r, rv, mil, en, seg};
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] b;
        b[3:0]   = 4'((n)        % 10);
        b[7:4]   = 4'((n / 10)   % 10);
        b[11:8]  = 4'((n / 100)  % 10);
        b[15:12] = 4'((n / 1000) % 10);
        return b;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    // Expectation for the outputs seen k rising edges from now.
    task automatic push_exp(input int k, input bit sel, input string name,
                            input logic [29:0] ev, input logic [29:0] mask);
        exp_t e;
        e.cyc = cyc + k; e.sel = sel; e.ev = ev; e.mask = mask; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [29:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = e.sel ? wrap_vec : main_vec;
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: slot for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if ((act & e.mask) !== (e.ev & e.mask)) begin
                errors++;
                $display("FAIL %s @cycle %0d: got %h, expected %h", e.name, cyc,
                         act & e.mask, e.ev & e.mask);
            end
        end
    end

    initial begin
        rst = 1'b0; state = 4'd0; power_now = 1'b0; tl = 1'b0; tr = 1'b0; rev = 1'b0;
        wstate = 4'd0; wpower = 1'b0;
        tick(1);
        push_exp(1, 0, "reset_state", 30'd0, M_ALL);
        tick(2);

        rst = 1'b1; power_now = 1'b1; state = 4'd1; tl = 1'b1;
        for (int k = 1; k <= 9; k++)
            push_exp(k, 0, "ns_left_scan",
                     vec(1, 0, 0, 16'h0000, 4'(4'b0001 << (((k - 1) / 2) % 4)), 7'h3F), M_ALL);
        tick(9);

        tl = 1'b0;
        push_exp(1, 0, "ns_left_off", 30'd0, M_LAMP);
        tick(1);

        state = 4'd2; tl = 1'b1; tr = 1'b1; rev = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            bit on;
            on = (((k - 1) / 4) % 2) == 0;
            push_exp(k, 0, "hazard_blink", vec(on, on, 1, 16'h0, 4'h0, 7'h0), M_LAMP);
        end
        tick(12);

        state = 4'd3; tl = 1'b0; tr = 1'b0; rev = 1'b0;
        push_exp(9,   0, "odo_before_first", vec(0, 0, 0, 16'h0000, 4'h0, 7'h0), M_MIL);
        push_exp(10,  0, "odo_first",        vec(0, 0, 0, 16'h0001, 4'h0, 7'h0), M_MIL);
        push_exp(107, 0, "odo_ten",          vec(0, 0, 0, 16'h0010, 4'h0, 7'h0), M_MIL);
        tick(107);

        state = 4'd2;
        push_exp(7, 0, "odo_hold_starting", vec(0, 0, 0, 16'h0010, 4'h0, 7'h0), M_MIL);
        tick(7);
        state = 4'd3;
        push_exp(2, 0, "odo_resume_pre", vec(0, 0, 0, 16'h0010, 4'h0, 7'h0), M_MIL);
        push_exp(3, 0, "odo_resume",     vec(0, 0, 0, 16'h0011, 4'h0, 7'h0), M_MIL);
        tick(3);

        push_exp(310, 0, "odo_42", vec(0, 0, 0, 16'h0042, 4'h0, 7'h0), M_MIL);
        tick(310);
        tl = 1'b1;
        push_exp(9, 0, "odo_before_wrap", vec(0, 0, 0, 16'h0042, 4'h0, 7'h0), M_MIL);
        tick(9);

        // Prescaler is at its last count here: the clear must win over the increment.
        power_now = 1'b0;
        push_exp(1, 0, "power_off_clear", 30'd0, M_ALL);
        push_exp(5, 0, "power_off_hold",  30'd0, M_ALL);
        tick(5);

        power_now = 1'b1; state = 4'd3; tl = 1'b0;
        push_exp(25, 0, "odo_repower", vec(0, 0, 0, 16'h0002, 4'h0, 7'h0), M_MIL);
        tick(25);

        state = 4'd9; tl = 1'b1; rev = 1'b1;
        push_exp(1,  0, "invalid_dark", vec(0, 0, 0, 16'h0002, 4'h0, 7'h0), M_ALL);
        push_exp(20, 0, "invalid_hold", vec(0, 0, 0, 16'h0002, 4'h0, 7'h0), M_ALL);
        tick(20);
        state = 4'd3; tl = 1'b0; rev = 1'b0;
        push_exp(4, 0, "invalid_resume_pre", vec(0, 0, 0, 16'h0002, 4'h0, 7'h0), M_MIL);
        push_exp(5, 0, "invalid_resume",     vec(0, 0, 0, 16'h0003, 4'h0, 7'h0), M_MIL);
        tick(5);

        tl = 1'b1;
        tick(3);
        @(posedge clk);
        #2;
        rst = 1'b0;
        push_exp(0, 0, "async_reset", 30'd0, M_ALL);
        tick(2);
        rst = 1'b1;
        push_exp(9,  0, "post_reset_pre",   vec(0, 0, 0, 16'h0000, 4'h0, 7'h0), M_MIL);
        push_exp(10, 0, "post_reset_first", vec(0, 0, 0, 16'h0001, 4'h0, 7'h0), M_MIL);
        tick(10);

        wpower = 1'b1; wstate = 4'd3;
        for (int k = 1; k <= 12; k++) begin
            int          idx;
            logic [15:0] p;
            idx = ((k - 1) / 2) % 4;
            p   = to_bcd(k - 1);
            push_exp(k, 1, "wrap_scan",
                     vec(0, 0, 0, to_bcd(k), 4'(4'b0001 << idx), seg7(p[4*idx +: 4])), M_ALL);
        end
        push_exp(100,   1, "carry_100",  vec(0, 0, 0, 16'h0100, 4'h0, 7'h0), M_MIL);
        push_exp(1000,  1, "carry_1000", vec(0, 0, 0, 16'h1000, 4'h0, 7'h0), M_MIL);
        push_exp(9999,  1, "odo_9999",   vec(0, 0, 0, 16'h9999, 4'h0, 7'h0), M_MIL);
        push_exp(10000, 1, "odo_rollover", vec(0, 0, 0, 16'h0000, 4'h0, 7'h0), M_MIL);
        tick(10000);

        for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
